// File: rtl/sht40_measure_sequencer.sv
// SHT40 measurement sequencer: measure-command write, conversion wait, 6-byte read with CRC-8
// checking, driven by a one-shot request or a free-running period timer.
module sht40_measure_sequencer #(
  parameter logic [6:0]  PERIPH_ADDR   = 7'h44,
  parameter logic [7:0]  MEAS_CMD      = 8'hFD,
  parameter int unsigned CONV_CYCLES   = 20000,
  parameter int unsigned PERIOD_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 24
) (
  input  logic        clk,
  input  logic        Reset_N,
  input  logic        Start_Measure,
  input  logic        Periodic_Enable,
  output logic        Busy,
  output logic        Cmd_Valid,
  input  logic        Cmd_Ready,
  output logic        Cmd_Rw,
  output logic [6:0]  Cmd_Address,
  output logic [7:0]  Cmd_Data,
  output logic [2:0]  Cmd_Read_Len,
  input  logic        Master_Done,
  input  logic        Master_Nack,
  input  logic        Rx_Valid,
  input  logic [7:0]  Rx_Data,
  output logic [15:0] Temperature_Output,
  output logic [15:0] Humidity_Output,
  output logic        Result_Valid,
  output logic        CRC_Error,
  output logic        Nack_Error,
  output logic [7:0]  Sample_Count
);

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrWait, StConv, StRdReq, StRdWait, StCheck
  } state_e;

  localparam logic [CNT_W-1:0] ConvLast   = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [7:0]       RetryMax   = 8'(MAX_RETRY);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  conv_q, conv_d;
  logic [7:0]        retry_q, retry_d;
  logic [2:0]        idx_q, idx_d;
  logic [5:0][7:0]   rx_q, rx_d;
  logic [15:0]       temp_q, temp_d;
  logic [15:0]       hum_q, hum_d;
  logic              valid_q, valid_d;
  logic              crc_err_q, crc_err_d;
  logic              nack_err_q, nack_err_d;
  logic [7:0]        count_q, count_d;
  logic              period_expire;
  logic              crc_ok;

  // CRC-8, poly 0x31, init 0xFF, MSB first over one 16-bit word.
  function automatic logic [7:0] crc8(input logic [15:0] word);
    logic [7:0] crc;
    crc = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ word[i]) crc = {crc[6:0], 1'b0} ^ 8'h31;
      else                  crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

  assign crc_ok = (crc8({rx_q[0], rx_q[1]}) == rx_q[2]) &&
                  (crc8({rx_q[3], rx_q[4]}) == rx_q[5]);
  assign period_expire = Periodic_Enable && (period_q == PeriodLast);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    period_d   = '0;
    conv_d     = '0;
    retry_d    = retry_q;
    idx_d      = idx_q;
    rx_d       = rx_q;
    temp_d     = temp_q;
    hum_d      = hum_q;
    valid_d    = 1'b0;
    crc_err_d  = crc_err_q;
    nack_err_d = nack_err_q;
    count_d    = count_q;

    if (Periodic_Enable && !period_expire) period_d = period_q + 1'b1;

    // A trigger arriving in the same cycle we leave IDLE stays pending for the next run.
    if (state_q == StIdle && pending_q) pending_d = 1'b0;
    if (Start_Measure || period_expire) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d    = StWrReq;
          crc_err_d  = 1'b0;
          nack_err_d = 1'b0;
          idx_d      = '0;
          retry_d    = '0;
        end
      end
      StWrReq: if (Cmd_Ready) state_d = StWrWait;
      StWrWait: begin
        if (Master_Done) begin
          if (!Master_Nack) begin
            state_d = StConv;
            retry_d = '0;
          end else if (retry_q < RetryMax) begin
            state_d = StWrReq;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d    = StIdle;
            nack_err_d = 1'b1;
          end
        end
      end
      StConv: begin
        conv_d = conv_q + 1'b1;
        if (conv_q == ConvLast) state_d = StRdReq;
      end
      StRdReq: begin
        if (Cmd_Ready) begin
          state_d = StRdWait;
          idx_d   = '0;
        end
      end
      StRdWait: begin
        if (Rx_Valid && idx_q < 3'd6) begin
          for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) rx_d[i] = Rx_Data;
          end
          idx_d = idx_q + 1'b1;
        end
        if (Master_Done) begin
          if (!Master_Nack) begin
            state_d = StCheck;
          end else if (retry_q < RetryMax) begin
            state_d = StConv;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d    = StIdle;
            nack_err_d = 1'b1;
          end
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (idx_q == 3'd6 && crc_ok) begin
          temp_d  = {rx_q[0], rx_q[1]};
          hum_d   = {rx_q[3], rx_q[4]};
          valid_d = 1'b1;
          count_d = count_q + 1'b1;
        end else begin
          crc_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      period_q   <= '0;
      conv_q     <= '0;
      retry_q    <= '0;
      idx_q      <= '0;
      rx_q       <= '0;
      temp_q     <= '0;
      hum_q      <= '0;
      valid_q    <= 1'b0;
      crc_err_q  <= 1'b0;
      nack_err_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      period_q   <= period_d;
      conv_q     <= conv_d;
      retry_q    <= retry_d;
      idx_q      <= idx_d;
      rx_q       <= rx_d;
      temp_q     <= temp_d;
      hum_q      <= hum_d;
      valid_q    <= valid_d;
      crc_err_q  <= crc_err_d;
      nack_err_q <= nack_err_d;
      count_q    <= count_d;
    end
  end

  // Command fields decode straight from state so Cmd_Valid falls with an asynchronous reset.
  assign Busy               = (state_q != StIdle);
  assign Cmd_Valid          = (state_q == StWrReq) || (state_q == StRdReq);
  assign Cmd_Rw             = (state_q == StRdReq);
  assign Cmd_Address        = PERIPH_ADDR;
  assign Cmd_Data           = (state_q == StWrReq) ? MEAS_CMD : 8'h00;
  assign Cmd_Read_Len       = (state_q == StRdReq) ? 3'd6 : 3'd0;
  assign Temperature_Output = temp_q;
  assign Humidity_Output    = hum_q;
  assign Result_Valid       = valid_q;
  assign CRC_Error          = crc_err_q;
  assign Nack_Error         = nack_err_q;
  assign Sample_Count       = count_q;

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Directed bench for sht40_measure_sequencer with a behavioural i2c_master responder.
module tb_sht40_measure_sequencer;

  localparam int CONV   = 20;
  localparam int PERIOD = 300;

  logic        clk;
  logic        Reset_N;
  logic        Start_Measure;
  logic        Periodic_Enable;
  logic        Busy;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic        Cmd_Rw;
  logic [6:0]  Cmd_Address;
  logic [7:0]  Cmd_Data;
  logic [2:0]  Cmd_Read_Len;
  logic        Master_Done;
  logic        Master_Nack;
  logic        Rx_Valid;
  logic [7:0]  Rx_Data;
  logic [15:0] Temperature_Output;
  logic [15:0] Humidity_Output;
  logic        Result_Valid;
  logic        CRC_Error;
  logic        Nack_Error;
  logic [7:0]  Sample_Count;

  sht40_measure_sequencer #(
    .PERIPH_ADDR  (7'h44),
    .MEAS_CMD     (8'hFD),
    .CONV_CYCLES  (CONV),
    .PERIOD_CYCLES(PERIOD),
    .MAX_RETRY    (3),
    .CNT_W        (24)
  ) dut (
    .clk               (clk),
    .Reset_N           (Reset_N),
    .Start_Measure     (Start_Measure),
    .Periodic_Enable   (Periodic_Enable),
    .Busy              (Busy),
    .Cmd_Valid         (Cmd_Valid),
    .Cmd_Ready         (Cmd_Ready),
    .Cmd_Rw            (Cmd_Rw),
    .Cmd_Address       (Cmd_Address),
    .Cmd_Data          (Cmd_Data),
    .Cmd_Read_Len      (Cmd_Read_Len),
    .Master_Done       (Master_Done),
    .Master_Nack       (Master_Nack),
    .Rx_Valid          (Rx_Valid),
    .Rx_Data           (Rx_Data),
    .Temperature_Output(Temperature_Output),
    .Humidity_Output   (Humidity_Output),
    .Result_Valid      (Result_Valid),
    .CRC_Error         (CRC_Error),
    .Nack_Error        (Nack_Error),
    .Sample_Count      (Sample_Count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder configuration and observations.
  int         wr_count = 0, rd_count = 0, rv_count = 0, rv_cyc = 0;
  int         last_done = 0, last_rd_done = 0, last_gap = 0, stable_bad = 0;
  int         wait_ready = 0, rx_delay = 2, rx_len = 6, wr_nack_left = 0, rd_nack_left = 0;
  int         wr_hs_q[$];
  logic [7:0] rx_bytes [6];
  logic [7:0] seen_wr_data, seen_rd_data;
  logic [6:0] seen_wr_addr, seen_rd_addr;
  logic [2:0] seen_wr_len, seen_rd_len;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (Result_Valid) begin
      rv_count++;
      rv_cyc = cyc;
    end
  end

  // Behavioural i2c_master: optional ready stall, then bytes and a Done pulse.
  initial begin
    logic       rw, nack;
    logic [7:0] d0;
    logic [2:0] l0;
    Cmd_Ready = 0; Master_Done = 0; Master_Nack = 0; Rx_Valid = 0; Rx_Data = 0;
    @(negedge clk);
    forever begin
      if (Cmd_Valid && Reset_N) begin
        rw = Cmd_Rw; d0 = Cmd_Data; l0 = Cmd_Read_Len;
        if (rw) begin
          rd_count++; seen_rd_data = Cmd_Data; seen_rd_len = Cmd_Read_Len;
          seen_rd_addr = Cmd_Address; last_gap = cyc - last_done;
        end else begin
          wr_count++; seen_wr_data = Cmd_Data; seen_wr_len = Cmd_Read_Len;
          seen_wr_addr = Cmd_Address;
        end
        for (int i = 0; i < wait_ready; i++) begin
          @(negedge clk);
          if (!Cmd_Valid || Cmd_Rw !== rw || Cmd_Data !== d0 || Cmd_Read_Len !== l0) stable_bad++;
        end
        Cmd_Ready = 1;
        if (!rw) wr_hs_q.push_back(cyc + 1);
        @(negedge clk);
        Cmd_Ready = 0;
        if (Cmd_Valid) stable_bad++;
        repeat (rw ? rx_delay : 2) @(negedge clk);
        if (rw) begin
          for (int i = 0; i < rx_len; i++) begin
            Rx_Valid = 1; Rx_Data = rx_bytes[i];
            @(negedge clk);
          end
          Rx_Valid = 0;
        end
        if (rw) begin nack = (rd_nack_left > 0); if (nack) rd_nack_left--; end
        else    begin nack = (wr_nack_left > 0); if (nack) wr_nack_left--; end
        Master_Done = 1; Master_Nack = nack;
        last_done = cyc + 1;
        if (rw) last_rd_done = cyc + 1;
        @(negedge clk);
        Master_Done = 0; Master_Nack = 0;
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic set_bytes(input logic [47:0] b);
    for (int i = 0; i < 6; i++) rx_bytes[i] = b[47 - 8*i -: 8];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    Start_Measure = 1;
    @(negedge clk);
    Start_Measure = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!Busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    Reset_N = 0; Start_Measure = 0; Periodic_Enable = 0;
    repeat (3) @(negedge clk);
    checks++; if (Busy !== 0 || Cmd_Valid !== 0) begin errors++;
      $display("FAIL reset_busy_valid got %b%b want 00", Busy, Cmd_Valid); end
    checks++; if (Cmd_Address !== 7'h44 || Cmd_Data !== 0 || Cmd_Read_Len !== 0 || Cmd_Rw !== 0)
      begin errors++; $display("FAIL reset_cmd got %h %h %h %b", Cmd_Address, Cmd_Data,
      Cmd_Read_Len, Cmd_Rw); end
    checks++; if ({Temperature_Output, Humidity_Output, Sample_Count} !== 40'h0) begin errors++;
      $display("FAIL reset_data got %h %h %h want 0", Temperature_Output, Humidity_Output,
      Sample_Count); end
    checks++; if ({Result_Valid, CRC_Error, Nack_Error} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b%b%b want 000", Result_Valid, CRC_Error, Nack_Error); end
    Reset_N = 1;
    @(negedge clk);
  endtask

  task automatic test_single_shot();
    bit ok;
    set_bytes(48'hBEEF92_BEEF92);
    wait_ready = 2;
    @(negedge clk);
    Start_Measure = 1;
    @(negedge clk);
    Start_Measure = 0;
    checks++; if (Cmd_Valid !== 0) begin errors++;
      $display("FAIL start_latency_early Cmd_Valid got %b want 0", Cmd_Valid); end
    @(negedge clk);
    checks++; if (Cmd_Valid !== 1 || Busy !== 1) begin errors++;
      $display("FAIL start_latency Cmd_Valid/Busy got %b%b want 11", Cmd_Valid, Busy); end
    wait_idle(300, ok);
    wait_ready = 0;
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout Busy got 1 want 0"); end
    checks++; if (wr_count !== 1 || rd_count !== 1) begin errors++;
      $display("FAIL single_txn_count got wr=%0d rd=%0d want 1 1", wr_count, rd_count); end
    checks++; if (seen_wr_data !== 8'hFD || seen_wr_addr !== 7'h44 || seen_wr_len !== 0) begin
      errors++; $display("FAIL single_write_fields got %h %h %h want fd 44 0", seen_wr_data,
      seen_wr_addr, seen_wr_len); end
    checks++; if (seen_rd_data !== 0 || seen_rd_addr !== 7'h44 || seen_rd_len !== 3'd6) begin
      errors++; $display("FAIL single_read_fields got %h %h %h want 0 44 6", seen_rd_data,
      seen_rd_addr, seen_rd_len); end
    checks++; if (stable_bad !== 0) begin errors++;
      $display("FAIL cmd_stable violations got %0d want 0", stable_bad); end
    checks++; if (last_gap !== CONV) begin errors++;
      $display("FAIL conv_gap got %0d want %0d", last_gap, CONV); end
    checks++; if (Temperature_Output !== 16'hBEEF || Humidity_Output !== 16'hBEEF) begin errors++;
      $display("FAIL single_data got %h %h want beef beef", Temperature_Output,
      Humidity_Output); end
    checks++; if (rv_count !== 1 || rv_cyc !== last_rd_done + 1) begin errors++;
      $display("FAIL single_result_valid got n=%0d at %0d want 1 at %0d", rv_count, rv_cyc,
      last_rd_done + 1); end
    checks++; if (Sample_Count !== 8'd1 || CRC_Error !== 0 || Nack_Error !== 0) begin errors++;
      $display("FAIL single_status got cnt=%0d crc=%b nack=%b want 1 0 0", Sample_Count,
      CRC_Error, Nack_Error); end
  endtask

  task automatic test_crc_fail();
    bit ok;
    set_bytes(48'h000081_BEEF93);
    pulse_start();
    wait_idle(300, ok);
    checks++; if (!ok || CRC_Error !== 1) begin errors++;
      $display("FAIL crc_fail_flag got %b want 1", CRC_Error); end
    checks++; if (Temperature_Output !== 16'hBEEF || Humidity_Output !== 16'hBEEF) begin errors++;
      $display("FAIL crc_fail_hold got %h %h want beef beef", Temperature_Output,
      Humidity_Output); end
    checks++; if (rv_count !== 1 || Sample_Count !== 8'd1) begin errors++;
      $display("FAIL crc_fail_count got rv=%0d cnt=%0d want 1 1", rv_count, Sample_Count); end
  endtask

  task automatic test_read_nack();
    bit ok;
    int wr0, rd0;
    wr0 = wr_count; rd0 = rd_count;
    set_bytes(48'h000081_BEEF92);
    rd_nack_left = 2;
    pulse_start();
    wait_idle(400, ok);
    checks++; if (!ok || rd_count - rd0 !== 3 || wr_count - wr0 !== 1) begin errors++;
      $display("FAIL read_nack_txns got rd=%0d wr=%0d want 3 1", rd_count - rd0,
      wr_count - wr0); end
    checks++; if (last_gap !== CONV) begin errors++;
      $display("FAIL read_retry_conv got %0d want %0d", last_gap, CONV); end
    checks++; if (Temperature_Output !== 16'h0000 || Humidity_Output !== 16'hBEEF) begin
      errors++; $display("FAIL read_nack_data got %h %h want 0000 beef", Temperature_Output,
      Humidity_Output); end
    checks++; if (Sample_Count !== 8'd2 || CRC_Error !== 0 || Nack_Error !== 0) begin errors++;
      $display("FAIL read_nack_status got cnt=%0d crc=%b nack=%b want 2 0 0", Sample_Count,
      CRC_Error, Nack_Error); end
  endtask

  task automatic test_write_nack();
    bit ok;
    int wr0, rd0, rv0;
    wr0 = wr_count; rd0 = rd_count; rv0 = rv_count;
    wr_nack_left = 4;
    pulse_start();
    wait_idle(300, ok);
    checks++; if (!ok || Nack_Error !== 1) begin errors++;
      $display("FAIL write_nack_flag got busy=%b nack=%b want 0 1", Busy, Nack_Error); end
    repeat (30) @(negedge clk);
    checks++; if (wr_count - wr0 !== 4 || rd_count - rd0 !== 0) begin errors++;
      $display("FAIL write_nack_txns got wr=%0d rd=%0d want 4 0", wr_count - wr0,
      rd_count - rd0); end
    checks++; if (Nack_Error !== 1 || Busy !== 0 || rv_count !== rv0 || Sample_Count !== 8'd2)
      begin errors++; $display("FAIL write_nack_hold got nack=%b busy=%b cnt=%0d want 1 0 2",
      Nack_Error, Busy, Sample_Count); end
  endtask

  task automatic test_short_read();
    bit ok;
    int rv0;
    rv0 = rv_count;
    set_bytes(48'hBEEF92_BEEF92);
    rx_len = 4;
    pulse_start();
    wait_idle(300, ok);
    rx_len = 6;
    checks++; if (!ok || CRC_Error !== 1 || Nack_Error !== 0) begin errors++;
      $display("FAIL short_read_flags got crc=%b nack=%b want 1 0", CRC_Error, Nack_Error); end
    checks++; if (Temperature_Output !== 16'h0000 || rv_count !== rv0 || Sample_Count !== 8'd2)
      begin errors++; $display("FAIL short_read_hold got t=%h cnt=%0d want 0000 2",
      Temperature_Output, Sample_Count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int en_cyc, rv0, wr0;
    wr_hs_q.delete();
    rv0 = rv_count;
    @(negedge clk);
    Periodic_Enable = 1;
    en_cyc = cyc;
    ok = 0;
    for (int i = 0; i < PERIOD + 50; i++) begin
      @(negedge clk);
      if (wr_hs_q.size() >= 1) begin ok = 1; break; end
    end
    repeat (10) @(negedge clk);
    Start_Measure = 1;
    @(negedge clk);
    Start_Measure = 0;
    for (int i = 0; i < 2 * PERIOD + 100 && wr_hs_q.size() < 3; i++) @(negedge clk);
    wait_idle(300, ok);
    Periodic_Enable = 0;
    checks++; if (wr_hs_q.size() < 3) begin errors++;
      $display("FAIL periodic_starts got %0d want 3", wr_hs_q.size()); end
    else begin
      checks++; if (wr_hs_q[0] - en_cyc !== PERIOD + 2) begin errors++;
        $display("FAIL periodic_first got %0d want %0d", wr_hs_q[0] - en_cyc, PERIOD + 2); end
      checks++; if (wr_hs_q[2] - wr_hs_q[0] !== PERIOD) begin errors++;
        $display("FAIL periodic_spacing got %0d want %0d", wr_hs_q[2] - wr_hs_q[0], PERIOD); end
      checks++; if (wr_hs_q[1] - wr_hs_q[0] >= PERIOD / 2) begin errors++;
        $display("FAIL back_to_back_gap got %0d want < %0d", wr_hs_q[1] - wr_hs_q[0],
        PERIOD / 2); end
    end
    checks++; if (rv_count - rv0 !== 3 || Sample_Count !== 8'd5) begin errors++;
      $display("FAIL periodic_results got rv=%0d cnt=%0d want 3 5", rv_count - rv0,
      Sample_Count); end
    wr0 = wr_count;
    repeat (PERIOD + 20) @(negedge clk);
    checks++; if (wr_count !== wr0) begin errors++;
      $display("FAIL periodic_disabled got %0d extra writes want 0", wr_count - wr0); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int rd0;
    rd0 = rd_count;
    rx_delay = 10;
    pulse_start();
    for (int i = 0; i < 200 && rd_count == rd0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (Busy !== 1) begin errors++; $display("FAIL mid_read_busy got 0 want 1"); end
    Reset_N = 0;
    #1;
    checks++; if (Busy !== 0 || Cmd_Valid !== 0 || Sample_Count !== 0) begin errors++;
      $display("FAIL async_reset got busy=%b valid=%b cnt=%0d want 0 0 0", Busy, Cmd_Valid,
      Sample_Count); end
    checks++; if (Temperature_Output !== 0 || Humidity_Output !== 0 || Cmd_Address !== 7'h44)
      begin errors++; $display("FAIL async_reset_data got %h %h %h want 0 0 44",
      Temperature_Output, Humidity_Output, Cmd_Address); end
    repeat (25) @(negedge clk);
    Reset_N = 1;
    rx_delay = 2;
    @(negedge clk);
    pulse_start();
    wait_idle(300, ok);
    checks++; if (!ok || Sample_Count !== 8'd1 || Temperature_Output !== 16'hBEEF) begin errors++;
      $display("FAIL after_reset got cnt=%0d t=%h want 1 beef", Sample_Count,
      Temperature_Output); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_crc_fail();
    test_read_nack();
    test_write_nack();
    test_short_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
